// File: rtl/mac_accum_ctrl_pkg.sv
// Shared definitions for the MAC accumulator controller: default operand,
// partial-sum and beat-counter widths, the FSM state encoding, and the
// signed-overflow helper used by the datapath.
package mac_accum_ctrl_pkg;

  // Default widths, shared with the array and BIST logic.
  localparam int DEF_A_WIDTH   = 8;
  localparam int DEF_W_WIDTH   = 8;
  localparam int DEF_P_WIDTH   = 32;
  localparam int DEF_CNT_WIDTH = 16;

  // Controller state encoding.
  localparam logic [0:0] ST_ACC = 1'b0;
  localparam logic [0:0] ST_OUT = 1'b1;

  // Two's-complement add overflow: both operands share a sign and the
  // result sign differs from it.
  function automatic logic add_ovf(input logic a_sign,
                                   input logic b_sign,
                                   input logic r_sign);
    return (a_sign == b_sign) && (r_sign != a_sign);
  endfunction

endpackage

// File: rtl/mac_accum_ctrl_mac_unit.sv
// Combinational multiply-accumulate: out_sum = in_a * in_w + in_p.
// The product is computed at full signed precision, sign-extended to the
// partial-sum width, and added with wrap-around. out_ovf flags a signed
// overflow of that add.
module mac_unit
  import mac_accum_ctrl_pkg::*;
#(
  parameter int A_WIDTH = DEF_A_WIDTH,
  parameter int W_WIDTH = DEF_W_WIDTH,
  parameter int P_WIDTH = DEF_P_WIDTH
) (
  input  logic [A_WIDTH-1:0] in_a,
  input  logic [W_WIDTH-1:0] in_w,
  input  logic [P_WIDTH-1:0] in_p,
  output logic [P_WIDTH-1:0] out_sum,
  output logic               out_ovf
);

  localparam int M_WIDTH = A_WIDTH + W_WIDTH;

  logic signed [M_WIDTH-1:0] w_a_ext;
  logic signed [M_WIDTH-1:0] w_w_ext;
  logic signed [M_WIDTH-1:0] w_prod;
  logic        [P_WIDTH-1:0] w_prod_ext;
  logic        [P_WIDTH-1:0] w_sum;

  // Full-precision signed product, sign-extended, then a wrapping add.
  always_comb begin
    w_a_ext    = M_WIDTH'($signed(in_a));
    w_w_ext    = M_WIDTH'($signed(in_w));
    w_prod     = w_a_ext * w_w_ext;
    w_prod_ext = P_WIDTH'(w_prod);
    w_sum      = w_prod_ext + in_p;
  end

  // Drive results and detect signed overflow of the accumulate step.
  always_comb begin
    out_sum = w_sum;
    out_ovf = add_ovf(w_prod_ext[P_WIDTH-1], in_p[P_WIDTH-1], w_sum[P_WIDTH-1]);
  end

endmodule

// File: rtl/mac_accum_ctrl.sv
// Dot-product accumulator controller. Accepts (activation, weight) beats in
// the ACC state, accumulates their products through a single mac_unit, and
// on the last beat presents the result in the OUT state until the consumer
// takes it. in_ready / out_valid are registered copies of the state so no
// combinational path exists from in_valid or out_ready.
module mac_accum_ctrl
  import mac_accum_ctrl_pkg::*;
#(
  parameter int A_WIDTH   = DEF_A_WIDTH,
  parameter int W_WIDTH   = DEF_W_WIDTH,
  parameter int P_WIDTH   = DEF_P_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   in_a,
  input  logic [W_WIDTH-1:0]   in_w,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [P_WIDTH-1:0]   out_sum,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_ovf
);

  logic [0:0]           r_state;
  logic [P_WIDTH-1:0]   r_acc;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_ovf;
  logic                 r_in_ready;
  logic                 r_out_valid;

  logic [0:0]           w_state_nxt;
  logic [P_WIDTH-1:0]   w_acc_nxt;
  logic [CNT_WIDTH-1:0] w_count_nxt;
  logic                 w_ovf_nxt;
  logic [CNT_WIDTH-1:0] w_count_inc;
  logic [P_WIDTH-1:0]   w_mac_sum;
  logic                 w_mac_ovf;
  logic                 w_accept;
  logic                 w_consume;

  mac_unit #(
    .A_WIDTH (A_WIDTH),
    .W_WIDTH (W_WIDTH),
    .P_WIDTH (P_WIDTH)
  ) u_mac (
    .in_a    (in_a),
    .in_w    (in_w),
    .in_p    (r_acc),
    .out_sum (w_mac_sum),
    .out_ovf (w_mac_ovf)
  );

  // Handshake qualifiers and saturating beat-count increment.
  always_comb begin
    w_accept  = in_valid & r_in_ready;
    w_consume = out_ready & r_out_valid;
    if (r_count == {CNT_WIDTH{1'b1}}) begin
      w_count_inc = r_count;
    end else begin
      w_count_inc = r_count + CNT_WIDTH'(1);
    end
  end

  // Next-state logic: clear overrides everything, then beat accept in ACC
  // or result consumption in OUT.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_count_nxt = r_count;
    w_ovf_nxt   = r_ovf;
    if (clear) begin
      w_state_nxt = ST_ACC;
      w_acc_nxt   = {P_WIDTH{1'b0}};
      w_count_nxt = {CNT_WIDTH{1'b0}};
      w_ovf_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_ACC: begin
          if (w_accept) begin
            w_acc_nxt   = w_mac_sum;
            w_count_nxt = w_count_inc;
            w_ovf_nxt   = r_ovf | w_mac_ovf;
            if (in_last) begin
              w_state_nxt = ST_OUT;
            end else begin
              w_state_nxt = ST_ACC;
            end
          end else begin
            w_state_nxt = ST_ACC;
          end
        end
        ST_OUT: begin
          if (w_consume) begin
            w_state_nxt = ST_ACC;
            w_acc_nxt   = {P_WIDTH{1'b0}};
            w_count_nxt = {CNT_WIDTH{1'b0}};
            w_ovf_nxt   = 1'b0;
          end else begin
            w_state_nxt = ST_OUT;
          end
        end
        default: begin
          w_state_nxt = ST_ACC;
          w_acc_nxt   = {P_WIDTH{1'b0}};
          w_count_nxt = {CNT_WIDTH{1'b0}};
          w_ovf_nxt   = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers; handshake flags track the next state so
  // in_ready stays low throughout reset and rises one cycle after release.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_ACC;
      r_acc       <= {P_WIDTH{1'b0}};
      r_count     <= {CNT_WIDTH{1'b0}};
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_count     <= w_count_nxt;
      r_ovf       <= w_ovf_nxt;
      r_in_ready  <= (w_state_nxt == ST_ACC);
      r_out_valid <= (w_state_nxt == ST_OUT);
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    in_ready  = r_in_ready;
    out_valid = r_out_valid;
    out_sum   = r_acc;
    out_count = r_count;
    out_ovf   = r_ovf;
  end

endmodule

// File: tb/tb_mac_accum_ctrl.sv
// Self-checking bench for mac_accum_ctrl. A 32-bit instance covers the main
// scenarios; a 16-bit / 2-bit-counter instance driven by the same inputs
// covers partial-sum wrap, overflow flag and count saturation.
module tb_mac_accum_ctrl;

  logic        clk = 1'b0;
  logic        rst, clear, in_valid, in_last, out_ready;
  logic [7:0]  in_a, in_w;
  logic        in_ready, out_valid, out_ovf;
  logic [31:0] out_sum;
  logic [15:0] out_count;
  logic        in_ready16, out_valid16, out_ovf16;
  logic [15:0] out_sum16;
  logic [1:0]  out_count16;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mac_accum_ctrl #(.A_WIDTH(8), .W_WIDTH(8), .P_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_w(in_w), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  mac_accum_ctrl #(.A_WIDTH(8), .W_WIDTH(8), .P_WIDTH(16), .CNT_WIDTH(2)) dut16 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready16),
    .in_a(in_a), .in_w(in_w), .in_last(in_last), .out_valid(out_valid16),
    .out_ready(out_ready), .out_sum(out_sum16), .out_count(out_count16), .out_ovf(out_ovf16)
  );

  // Wrap an exact integer into the signed range of a pw-bit register.
  function automatic longint wrap_pw(input longint v, input int pw);
    longint m, h, r;
    m = longint'(1) << pw;
    h = m >> 1;
    r = v % m;
    if (r < 0) r += m;
    if (r >= h) r -= m;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat once in_ready is high; it is accepted on the next edge.
  task automatic send_beat(input int a, input int w, input bit last);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_wait: in_ready=%b required 1 within 20 cycles", in_ready);
    end
    in_valid = 1'b1;
    in_a     = 8'(a);
    in_w     = 8'(w);
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_a = 8'd0; in_w = 8'd0;
    step();
    step();
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    checks++; if (out_sum !== 32'd0) begin fails++; $display("FAIL reset_sum: got %0d required 0", out_sum); end
    checks++; if (out_count !== 16'd0) begin fails++; $display("FAIL reset_count: got %0d required 0", out_count); end
    checks++; if (out_ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b required 0", out_ovf); end
    rst = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_in_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_basic();
    send_beat(5, 10, 1'b0);
    send_beat(-5, 10, 1'b0);
    send_beat(-5, -10, 1'b1);
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b required 1", out_valid); end
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL basic_in_ready: got %b required 0", in_ready); end
    checks++; if ($signed(out_sum) !== 32'sd50) begin fails++; $display("FAIL basic_sum: got %0d required 50", $signed(out_sum)); end
    checks++; if (out_count !== 16'd3) begin fails++; $display("FAIL basic_count: got %0d required 3", out_count); end
    checks++; if (out_ovf !== 1'b0) begin fails++; $display("FAIL basic_ovf: got %b required 0", out_ovf); end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a = 8'($urandom_range(0, 255));
      in_w = 8'($urandom_range(1, 255));
      in_last = 1'($urandom_range(0, 1));
      step();
      checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL hold_valid[%0d]: got %b required 1", i, out_valid); end
      checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL hold_in_ready[%0d]: got %b required 0", i, in_ready); end
      checks++; if ($signed(out_sum) !== 32'sd50) begin fails++; $display("FAIL hold_sum[%0d]: got %0d required 50", i, $signed(out_sum)); end
      checks++; if (out_count !== 16'd3) begin fails++; $display("FAIL hold_count[%0d]: got %0d required 3", i, out_count); end
    end
    in_valid = 1'b0; in_last = 1'b0;
    consume();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL consume_valid: got %b required 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL consume_in_ready: got %b required 1", in_ready); end
    checks++; if (out_sum !== 32'd0) begin fails++; $display("FAIL consume_sum: got %0d required 0", out_sum); end
    send_beat(120, 0, 1'b1);
    checks++; if (out_sum !== 32'd0) begin fails++; $display("FAIL zero_w_sum: got %0d required 0", $signed(out_sum)); end
    checks++; if (out_count !== 16'd1) begin fails++; $display("FAIL zero_w_count: got %0d required 1", out_count); end
    consume();
  endtask

  task automatic test_wrap();
    send_beat(127, 127, 1'b0);
    send_beat(127, 127, 1'b0);
    send_beat(127, 127, 1'b1);
    checks++; if (out_sum16 !== 16'd48387) begin fails++; $display("FAIL wrap_sum16: got %0d required -17149", $signed(out_sum16)); end
    checks++; if (out_ovf16 !== 1'b1) begin fails++; $display("FAIL wrap_ovf16: got %b required 1", out_ovf16); end
    checks++; if (out_sum !== 32'd48387) begin fails++; $display("FAIL wrap_sum32: got %0d required 48387", $signed(out_sum)); end
    checks++; if (out_ovf !== 1'b0) begin fails++; $display("FAIL wrap_ovf32: got %b required 0", out_ovf); end
    consume();
    send_beat(1, 1, 1'b1);
    checks++; if (out_ovf16 !== 1'b0) begin fails++; $display("FAIL wrap_next_ovf16: got %b required 0", out_ovf16); end
    checks++; if (out_sum16 !== 16'd1) begin fails++; $display("FAIL wrap_next_sum16: got %0d required 1", $signed(out_sum16)); end
    consume();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 5; i++) send_beat(1, 1, (i == 4));
    checks++; if (out_count !== 16'd5) begin fails++; $display("FAIL sat_count32: got %0d required 5", out_count); end
    checks++; if (out_count16 !== 2'd3) begin fails++; $display("FAIL sat_count16: got %0d required 3", out_count16); end
    checks++; if (out_sum16 !== 16'd5) begin fails++; $display("FAIL sat_sum16: got %0d required 5", out_sum16); end
    consume();
  endtask

  task automatic test_clear();
    send_beat(5, 10, 1'b0);
    send_beat(5, 10, 1'b0);
    in_valid = 1'b1; in_a = 8'd5; in_w = 8'd10; in_last = 1'b1; clear = 1'b1;
    step();
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL clear_valid: got %b required 0", out_valid); end
    checks++; if (out_count !== 16'd0) begin fails++; $display("FAIL clear_count: got %0d required 0", out_count); end
    checks++; if (out_sum !== 32'd0) begin fails++; $display("FAIL clear_sum: got %0d required 0", out_sum); end
    step();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL clear_valid_later: got %b required 0", out_valid); end
    send_beat(-5, -10, 1'b1);
    checks++; if ($signed(out_sum) !== 32'sd50) begin fails++; $display("FAIL clear_next_sum: got %0d required 50", $signed(out_sum)); end
    checks++; if (out_count !== 16'd1) begin fails++; $display("FAIL clear_next_count: got %0d required 1", out_count); end
    consume();
  endtask

  task automatic test_rst_out();
    send_beat(10, 15, 1'b1);
    checks++; if (out_sum !== 32'd150) begin fails++; $display("FAIL rst_pre_sum: got %0d required 150", out_sum); end
    rst = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    checks++; if (out_sum !== 32'd0) begin fails++; $display("FAIL rst_out_sum: got %0d required 0", out_sum); end
    checks++; if (out_count !== 16'd0) begin fails++; $display("FAIL rst_out_count: got %0d required 0", out_count); end
    rst = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_out_release: got %b required 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    int     ba[$];
    int     bw[$];
    bit     bl[$];
    longint exp_sum[$];
    int     exp_cnt[$];
    bit     exp_ovf[$];
    int     npkt, idx, got, lows, cyc, len;
    longint acc, t, h, es;
    bit     ov;
    npkt = 8;
    h = longint'(1) << 31;
    for (int p = 0; p < npkt; p++) begin
      len = $urandom_range(1, 5);
      acc = 0; ov = 1'b0;
      for (int j = 0; j < len; j++) begin
        ba.push_back(int'($urandom_range(0, 255)) - 128);
        bw.push_back(int'($urandom_range(0, 255)) - 128);
        bl.push_back(j == len - 1);
        t = acc + longint'(ba[$]) * longint'(bw[$]);
        if (t >= h || t < -h) ov = 1'b1;
        acc = wrap_pw(t, 32);
      end
      exp_sum.push_back(acc);
      exp_cnt.push_back(len);
      exp_ovf.push_back(ov);
    end
    out_ready = 1'b1;
    idx = 0; got = 0; lows = 0; cyc = 0;
    while (got < npkt && cyc < 500) begin
      if (in_ready !== 1'b1) lows++;
      if (out_valid === 1'b1) begin
        es = exp_sum.pop_front();
        checks++; if (out_sum !== es[31:0]) begin fails++; $display("FAIL b2b_sum[%0d]: got %0d required %0d", got, $signed(out_sum), es); end
        checks++; if (out_count !== 16'(exp_cnt[0])) begin fails++; $display("FAIL b2b_count[%0d]: got %0d required %0d", got, out_count, exp_cnt[0]); end
        checks++; if (out_ovf !== exp_ovf[0]) begin fails++; $display("FAIL b2b_ovf[%0d]: got %b required %b", got, out_ovf, exp_ovf[0]); end
        void'(exp_cnt.pop_front());
        void'(exp_ovf.pop_front());
        got++;
      end
      if (idx < ba.size()) begin
        in_valid = 1'b1;
        in_a = 8'(ba[idx]);
        in_w = 8'(bw[idx]);
        in_last = bl[idx];
        if (in_ready === 1'b1) idx++;
      end else begin
        in_valid = 1'b0;
        in_last = 1'b0;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    checks++; if (got !== npkt) begin fails++; $display("FAIL b2b_results: got %0d required %0d", got, npkt); end
    checks++; if (lows !== npkt) begin fails++; $display("FAIL b2b_ready_low_cycles: got %0d required %0d", lows, npkt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_wrap();
    test_saturate();
    test_clear();
    test_rst_out();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mac_accum_ctrl.md
MAC_ACCUM_CTRL -- requirements
Module: mac_accum_ctrl

Interface
REQ-001 SHALL have parameter A_WIDTH, default 8, signed activation width.
REQ-002 SHALL have parameter W_WIDTH, default 8, signed weight width.
REQ-003 SHALL have parameter P_WIDTH, default 32, signed partial-sum width.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, beat-counter width.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 clear  input  1  synchronous abort of the current accumulation.
REQ-009 in_valid  input  1  operand beat valid.
REQ-010 in_ready  output  1  block accepts a beat this cycle.
REQ-011 in_a  input  A_WIDTH  signed activation.
REQ-012 in_w  input  W_WIDTH  signed weight.
REQ-013 in_last  input  1  final beat of the current dot product.
REQ-014 out_valid  output  1  result available.
REQ-015 out_ready  input  1  consumer accepts the result.
REQ-016 out_sum  output  P_WIDTH  signed dot-product result.
REQ-017 out_count  output  CNT_WIDTH  number of beats accumulated.
REQ-018 out_ovf  output  1  sticky signed-overflow flag for this result.

Function
REQ-019 SHALL implement two states: ACC (in_ready=1, out_valid=0) and OUT (in_ready=0, out_valid=1).
REQ-020 Beat accept SHALL occur when in_valid&in_ready; acc_next = in_a*in_w + acc, computed by the mac_unit sub-module, with in_p=acc.
REQ-021 The product SHALL be a full signed product, sign-extended to P_WIDTH; the sum SHALL wrap modulo 2^P_WIDTH.
REQ-022 out_ovf SHALL set on any accepted beat whose signed add overflows (operand signs equal, result sign differs) and stay set until the result is consumed.
REQ-023 out_count SHALL increment per accepted beat and saturate at 2^CNT_WIDTH-1.
REQ-024 An accept with in_last=1 SHALL move ACC->OUT; out_valid SHALL rise on the next cycle, with out_sum/out_count/out_ovf including that beat.
REQ-025 In OUT, out_sum/out_count/out_ovf SHALL hold stable while out_ready=0.
REQ-026 out_valid&out_ready SHALL move OUT->ACC and zero acc, count, and ovf on the same edge; in_ready SHALL be 1 in the following cycle.
REQ-027 A single-beat packet (in_last on the first beat) SHALL yield out_sum = in_a*in_w and out_count=1.
REQ-028 clear=1 SHALL zero acc, count, and ovf and force ACC, discarding any beat offered that cycle and any pending OUT result.
REQ-029 clear and rst SHALL take priority over accept and output handshake in the same cycle.
REQ-030 in_ready and out_valid SHALL be pure functions of state (no combinational path from in_valid/out_ready).

Reset
REQ-031 On rst: state=ACC; acc=0; out_sum=0; out_count=0; out_ovf=0; out_valid=0; in_ready=0 during the reset cycle and 1 on the first cycle after rst deasserts.
REQ-032 rst mid-packet or during OUT SHALL discard all accumulated data without producing out_valid.

Structure
REQ-033 The default widths A_WIDTH/W_WIDTH/P_WIDTH/CNT_WIDTH and the state encoding (ACC=0, OUT=1) SHALL live in a shared package used by the array and the BIST logic.
REQ-034 SHALL instantiate exactly one mac_unit (combinational a*w+p) as its datapath sub-module; registers and the FSM stay in mac_accum_ctrl.

Verification
REQ-035 Beats (5,10),(-5,10),(-5,-10,last) -> out_sum=50, out_count=3, out_ovf=0, out_valid one cycle after the last accept.
REQ-036 out_ready held low for 3 cycles in OUT -> out_sum stable, in_ready=0, in_valid beats ignored; out_ready=1 -> next packet (120,0,last) gives out_sum=0, out_count=1.
REQ-037 P_WIDTH=16, three beats (127,127) with last -> out_sum=-17149 (wrapped 48387), out_ovf=1; next packet (1,1,last) -> out_ovf=0, out_sum=1.
REQ-038 Beats (5,10),(5,10), then clear together with a valid beat -> no out_valid; next packet (-5,-10,last) -> out_sum=50, out_count=1.
REQ-039 rst asserted in OUT holding 150 -> out_valid=0, out_sum=0, out_count=0 next cycle; in_ready=1 after release.
REQ-040 Back-to-back packets, out_ready tied 1 -> in_ready low for exactly one cycle per result; every packet sum matches the reference model.
